// File: rtl/amo_pkg.sv
// Op codes, FSM state type and read-modify-write compute function for amo_sequencer.
// Optional macro AMO_MINMAX_EN adds signed MIN (101) and MAX (110).
package amo_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SWAP = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MIN  = 3'b101;
    localparam logic [2:0] OP_MAX  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MODIFY = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    function automatic logic op_supported(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SWAP, OP_AND, OP_OR, OP_XOR: op_supported = 1'b1;
`ifdef AMO_MINMAX_EN
            OP_MIN, OP_MAX: op_supported = 1'b1;
`endif
            default: op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] amo_compute(input logic [31:0] old_val,
                                                input logic [31:0] rs2,
                                                input logic [2:0]  op);
        case (op)
            OP_ADD:  amo_compute = old_val + rs2;
            OP_SWAP: amo_compute = rs2;
            OP_AND:  amo_compute = old_val & rs2;
            OP_OR:   amo_compute = old_val | rs2;
            OP_XOR:  amo_compute = old_val ^ rs2;
`ifdef AMO_MINMAX_EN
            OP_MIN:  amo_compute = ($signed(old_val) < $signed(rs2)) ? old_val : rs2;
            OP_MAX:  amo_compute = ($signed(old_val) < $signed(rs2)) ? rs2 : old_val;
`endif
            default: amo_compute = old_val;
        endcase
    endfunction

endpackage

// File: rtl/amo_rr_arbiter.sv
// Round-robin arbiter starting after last_grant_i; when locked only the owner may win.
module amo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    input  logic               lock_en_i,
    input  logic [IDX_W-1:0]   lock_owner_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Pick the first requester after last_grant_i, wrapping at NUM_REQ.
    always_comb begin
        int   cand;
        logic found;
        logic hit;
        grant_o = {NUM_REQ{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        found   = 1'b0;
        hit     = 1'b0;
        cand    = 0;
        if (lock_en_i) begin
            grant_o[lock_owner_i] = req_i[lock_owner_i];
            idx_o                 = lock_owner_i;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand  = (int'(last_grant_i) + k) % NUM_REQ;
                hit   = !found && req_i[IDX_W'(cand)];
                grant_o[IDX_W'(cand)] = grant_o[IDX_W'(cand)] | hit;
                idx_o = hit ? IDX_W'(cand) : idx_o;
                found = found | hit;
            end
        end
    end

endmodule

// File: rtl/amo_sequencer.sv
// Round-robin AMO sequencer: indivisible read-modify-write on one memory port with aq/rl locking.
// Build macro AMO_MINMAX_EN enables signed MIN/MAX ops.
module amo_sequencer
    import amo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_data,
    input  logic [NUM_REQ*3-1:0]      req_op,
    input  logic [NUM_REQ-1:0]        req_aq,
    input  logic [NUM_REQ-1:0]        req_rl,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [31:0]               resp_data,
    output logic                      resp_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    lock_owner_q, lock_owner_d;
    logic                lock_q, lock_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         old_q, old_d;
    logic [31:0]         new_q, new_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [2:0]          op_q, op_d;
    logic                aq_q, aq_d, rl_q, rl_d, resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    gidx_s;
    logic                idle_s, accept_s, bad_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [2:0]          sel_op_s;

    amo_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .lock_en_i    (lock_q),
        .lock_owner_i (lock_owner_q),
        .grant_o      (grant_s),
        .idx_o        (gidx_s)
    );

    // Grants are offered only while idle and out of reset.
    assign idle_s     = (state_q == ST_IDLE) && rst_n;
    assign req_ready  = idle_s ? grant_s : {NUM_REQ{1'b0}};
    assign accept_s   = |(req_ready & req_valid);
    assign sel_addr_s = req_addr[gidx_s*ADDR_W +: ADDR_W];
    assign sel_op_s   = req_op[gidx_s*3 +: 3];
    assign bad_s      = (32'(sel_addr_s) >= 32'(DEPTH)) || !op_supported(sel_op_s);

    // Sequencer next-state, operand capture and lock bookkeeping.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        lock_owner_d = lock_owner_q;
        lock_d       = lock_q;
        addr_d       = addr_q;
        data_d       = data_q;
        old_d        = old_q;
        new_d        = new_q;
        resp_data_d  = resp_data_q;
        op_d         = op_q;
        aq_d         = aq_q;
        rl_d         = rl_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    idx_d        = gidx_s;
                    last_grant_d = gidx_s;
                    addr_d       = sel_addr_s;
                    data_d       = req_data[gidx_s*32 +: 32];
                    op_d         = sel_op_s;
                    aq_d         = req_aq[gidx_s];
                    rl_d         = req_rl[gidx_s];
                    if (bad_s) begin
                        state_d     = ST_RESP;
                        resp_data_d = 32'h0;
                        resp_err_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:   state_d = ST_MODIFY;
            ST_MODIFY: begin
                old_d   = mem_rdata;
                new_d   = amo_compute(mem_rdata, data_q, op_q);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                resp_data_d = old_q;
                resp_err_d  = 1'b0;
                // aq together with rl leaves the lock as it was.
                if (aq_q && !rl_q) begin
                    lock_d       = 1'b1;
                    lock_owner_d = idx_q;
                end else if (rl_q && !aq_q && lock_q && (lock_owner_q == idx_q)) begin
                    lock_d = 1'b0;
                end else begin
                    lock_d = lock_q;
                end
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IDX_W{1'b0}};
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            lock_owner_q <= {IDX_W{1'b0}};
            lock_q       <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= 32'h0;
            old_q        <= 32'h0;
            new_q        <= 32'h0;
            resp_data_q  <= 32'h0;
            op_q         <= 3'b000;
            aq_q         <= 1'b0;
            rl_q         <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            lock_owner_q <= lock_owner_d;
            lock_q       <= lock_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            old_q        <= old_d;
            new_q        <= new_d;
            resp_data_q  <= resp_data_d;
            op_q         <= op_d;
            aq_q         <= aq_d;
            rl_q         <= rl_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_en     = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = mem_en ? addr_q : {ADDR_W{1'b0}};
    assign mem_wdata  = mem_we ? new_q : 32'h0;
    assign resp_valid = (state_q == ST_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q)
                                             : {NUM_REQ{1'b0}};
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed plus randomized bench for amo_sequencer against a transaction-level memory/arbiter model.
module tb_amo_sequencer;

    localparam int NR = 4;
    localparam int AW = 9;
    localparam int DP = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_ready, req_aq, req_rl, resp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*32-1:0]  req_data;
    logic [NR*3-1:0]   req_op;
    logic [31:0]       resp_data, mem_wdata, mem_rdata;
    logic              resp_err, mem_en, mem_we;
    logic [AW-1:0]     mem_addr;

    logic [31:0] tb_mem  [0:511];
    logic [31:0] ref_mem [0:511];
    int rd_cnt = 0, wr_cnt = 0, cyc = 0;
    int checks = 0, fails = 0;
    int m_last = NR - 1, m_owner = 0;
    bit m_lock = 1'b0;

    always #5 clk = ~clk;

    amo_sequencer #(.NUM_REQ(NR), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_op(req_op), .req_aq(req_aq), .req_rl(req_rl),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        cyc++;
        if (mem_en) begin
            if (mem_we) begin
                tb_mem[mem_addr] = mem_wdata;
                wr_cnt++;
            end else begin
                mem_rdata <= tb_mem[mem_addr];
                rd_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [2:0] op, input logic aq, input logic rl);
        req_addr[i*AW +: AW] = a;
        req_data[i*32 +: 32] = d;
        req_op[i*3 +: 3]     = op;
        req_aq[i]            = aq;
        req_rl[i]            = rl;
    endtask

    task automatic scramble();
        req_valid = 4'($urandom());
        req_addr  = 36'({$urandom(), $urandom()});
        req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_op    = 12'($urandom());
        req_aq    = 4'($urandom());
        req_rl    = 4'($urandom());
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_req_ready"},  32'(req_ready),  32'h0);
        chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({pfx, "_resp_data"},  resp_data,       32'h0);
        chk({pfx, "_resp_err"},   32'(resp_err),   32'h0);
        chk({pfx, "_mem_en"},     32'(mem_en),     32'h0);
        chk({pfx, "_mem_we"},     32'(mem_we),     32'h0);
        chk({pfx, "_mem_addr"},   32'(mem_addr),   32'h0);
        chk({pfx, "_mem_wdata"},  mem_wdata,       32'h0);
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] o, input logic [31:0] r,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return o + r;
            3'd1:    return r;
            3'd2:    return o & r;
            3'd3:    return o | r;
            3'd4:    return o ^ r;
            3'd5:    return ($signed(o) < $signed(r)) ? o : r;
            3'd6:    return ($signed(o) > $signed(r)) ? o : r;
            default: return o;
        endcase
    endfunction

    function automatic logic ref_err(input logic [AW-1:0] a, input logic [2:0] op);
        logic bad_op;
`ifdef AMO_MINMAX_EN
        bad_op = (op == 3'd7);
`else
        bad_op = (op > 3'd4);
`endif
        return (int'(a) >= DP) || bad_op;
    endfunction

    function automatic int model_pick(input logic [NR-1:0] v);
        int c;
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NR; k++) begin
            c = (m_last + k) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One transaction: wait for accept, then follow it to the response against the model.
    task automatic do_txn(output int gidx, output int waited, output int acc_cyc);
        int e, r0, w0;
        logic [AW-1:0] a;
        logic [31:0] d, old, nw;
        logic [2:0] op;
        logic aq, rl, err;
        e = model_pick(req_valid);
        gidx = -1;
        acc_cyc = -1;
        waited = 0;
        if (e < 0) begin
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("stall_ready", 32'(req_ready), 32'h0);
                @(negedge clk);
            end
            waited = 4;
            return;
        end
        while (waited < 20) begin
            #1;
            if ((req_ready & req_valid) != 4'h0) break;
            @(negedge clk);
            waited++;
        end
        checks++;
        assert (waited < 20) else begin
            fails++;
            $error("FAIL accept_timeout: waited %0d cycles, required fewer than 20", waited);
        end
        if (waited >= 20) return;
        acc_cyc = cyc;
        gidx = e;
        chk("grant", 32'(req_ready), 32'(4'b0001 << e));
        a  = req_addr[e*AW +: AW];
        d  = req_data[e*32 +: 32];
        op = req_op[e*3 +: 3];
        aq = req_aq[e];
        rl = req_rl[e];
        err = ref_err(a, op);
        m_last = e;
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(negedge clk);
        if (err) begin
            chk("err_resp_valid", 32'(resp_valid), 32'(4'b0001 << e));
            chk("err_flag",       32'(resp_err),   32'h1);
            chk("err_data",       resp_data,       32'h0);
            chk("err_mem_en",     32'(mem_en),     32'h0);
            return;
        end
        old = ref_mem[a];
        nw  = ref_op(old, d, op);
        chk("read_en",    32'(mem_en),     32'h1);
        chk("read_we",    32'(mem_we),     32'h0);
        chk("read_addr",  32'(mem_addr),   32'(a));
        chk("resp_quiet", 32'(resp_valid), 32'h0);
        scramble();
        @(negedge clk);
        chk("modify_en",  32'(mem_en),     32'h0);
        chk("busy_ready", 32'(req_ready),  32'h0);
        @(negedge clk);
        chk("write_en",   32'(mem_en),     32'h1);
        chk("write_we",   32'(mem_we),     32'h1);
        chk("write_addr", 32'(mem_addr),   32'(a));
        chk("write_data", mem_wdata,       nw);
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'(4'b0001 << e));
        chk("resp_data",  resp_data,       old);
        chk("resp_err",   32'(resp_err),   32'h0);
        chk("read_count", 32'(rd_cnt - r0), 32'h1);
        chk("write_count", 32'(wr_cnt - w0), 32'h1);
        chk("mem_after",  tb_mem[a],       nw);
        ref_mem[a] = nw;
        if (aq && !rl) begin
            m_lock = 1'b1;
            m_owner = e;
        end else if (rl && !aq && m_lock && m_owner == e) begin
            m_lock = 1'b0;
        end
    endtask

    initial begin
        int g, w, ac, prev, w0;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] v;

        rst_n = 1'b0;
        req_valid = 4'hF;
        req_addr = '0; req_data = '0; req_op = '0; req_aq = '0; req_rl = '0;
        for (int i = 0; i < 512; i++) begin
            tb_mem[i] = $urandom();
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[16] = 32'd5;          ref_mem[16] = 32'd5;
        tb_mem[20] = 32'hFFFF_FFFE;  ref_mem[20] = 32'hFFFF_FFFE;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_quiet("reset");
        req_valid = 4'h0;
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin from reset: 0,1,2,3,0 at 5-cycle spacing.
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 9'(40 + i), $urandom(), 3'($urandom_range(0, 4)), 1'b0, 1'b0);
            req_valid = 4'hF;
            do_txn(g, w, ac);
            chk("rr_order", 32'(g), 32'(exp_order[k]));
            if (k > 0) chk("rr_spacing", 32'(ac - prev), 32'd5);
            prev = ac;
        end

        // Single ADD on preloaded word.
        set_req(0, 9'd16, 32'd3, 3'b000, 1'b0, 1'b0);
        req_valid = 4'b0001;
        do_txn(g, w, ac);
        chk("add_old", resp_data, 32'd5);
        chk("add_mem16", tb_mem[16], 32'd8);

        // Error requests: out-of-range address, op 111, op 101.
        set_req(2, 9'd300, 32'd1, 3'b000, 1'b0, 1'b0);
        req_valid = 4'b0100;
        do_txn(g, w, ac);
        chk("err_addr300", 32'(resp_err), 32'h1);
        set_req(3, 9'd16, 32'd1, 3'b111, 1'b1, 1'b0);
        req_valid = 4'b1000;
        do_txn(g, w, ac);
        chk("err_op7", 32'(resp_err), 32'h1);
        set_req(1, 9'd20, 32'd1, 3'b101, 1'b0, 1'b0);
        req_valid = 4'b0010;
        do_txn(g, w, ac);
`ifdef AMO_MINMAX_EN
        chk("min_mem20", tb_mem[20], 32'hFFFF_FFFE);
`else
        chk("op5_err", 32'(resp_err), 32'h1);
`endif

        // Lock: acquire by 1, stall 2, release by 1, then 2 is granted at once.
        set_req(1, 9'd50, 32'hA5A5_0001, 3'b001, 1'b1, 1'b0);
        req_valid = 4'b0010;
        do_txn(g, w, ac);
        set_req(2, 9'd51, 32'd9, 3'b000, 1'b0, 1'b0);
        req_valid = 4'b0100;
        do_txn(g, w, ac);
        set_req(1, 9'd50, 32'h0000_00F0, 3'b011, 1'b0, 1'b1);
        set_req(2, 9'd51, 32'd9, 3'b000, 1'b0, 1'b0);
        req_valid = 4'b0110;
        do_txn(g, w, ac);
        chk("lock_owner_grant", 32'(g), 32'd1);
        set_req(2, 9'd51, 32'd9, 3'b000, 1'b0, 1'b0);
        req_valid = 4'b0100;
        do_txn(g, w, ac);
        chk("lock_release_grant", 32'(g), 32'd2);
        chk("lock_release_wait",  32'(w), 32'd1);

        // Reset during MODIFY aborts the write.
        set_req(0, 9'd16, 32'd7, 3'b000, 1'b0, 1'b0);
        req_valid = 4'b0001;
        w = 0;
        #1;
        while (((req_ready & req_valid) == 4'h0) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        assert (w < 20) else begin
            fails++;
            $error("FAIL abort_accept_timeout: waited %0d cycles, required fewer than 20", w);
        end
        w0 = wr_cnt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_write", 32'(wr_cnt - w0), 32'h0);
        chk("abort_mem16", tb_mem[16], ref_mem[16]);
        m_last = NR - 1;
        m_lock = 1'b0;
        for (int i = 1; i < NR; i++)
            set_req(i, 9'(60 + i), $urandom(), 3'b010, 1'b0, 1'b0);
        set_req(0, 9'd16, 32'd7, 3'b000, 1'b0, 1'b0);
        req_valid = 4'hF;
        rst_n = 1'b1;
        do_txn(g, w, ac);
        chk("post_reset_grant", 32'(g), 32'd0);
        chk("post_reset_mem16", tb_mem[16], 32'd15);

        // Randomized traffic on a small address window with occasional errors and locks.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++)
                set_req(i,
                        ($urandom_range(0, 9) == 0) ? 9'(256 + $urandom_range(0, 255))
                                                    : 9'($urandom_range(0, 15)),
                        $urandom(), 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
            v = 4'($urandom_range(1, 15));
            if (m_lock) v = v | (4'b0001 << m_owner);
            req_valid = v;
            do_txn(g, w, ac);
        end

        req_valid = 4'h0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Shared-memory atomic memory operation (AMO) sequencer. It arbitrates `NUM_REQ` requesters round-robin onto a single synchronous memory port. Each granted request runs as an indivisible read-modify-write: read, compute, write back, then respond. The block sits between the core-side AMO issue ports and the shared data memory, and enforces acquire/release locking across requesters.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 8: memory word-address width.
- `DEPTH`, 256: valid words; any address >= `DEPTH` is an error.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_addr`  in  NUM_REQ*ADDR_W  packed word addresses; requester i occupies slice i.
- `req_data`  in  NUM_REQ*32  packed rs2 operands.
- `req_op`  in  NUM_REQ*3  packed funct3 fields.
- `req_aq`, `req_rl`  in  NUM_REQ  acquire and release flags.
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `resp_data`  out  32  old memory value; 0 on error.
- `resp_err`  out  1  qualified by `resp_valid`; set for a bad address or a bad op.
- `mem_en`, `mem_we`  out  1  memory strobes.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  valid one cycle after a read with `mem_en=1, mem_we=0`.

## Operation
- Op codes:
  - 000 ADD: new = old + rs2, modulo 2^32, carry dropped.
  - 001 SWAP: new = rs2.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - Any other code is an error unless enabled by the Configuration macro.
- `resp_data` always carries the pre-operation memory value (RISC-V rd semantics). Memory receives the new value.
- FSM states: IDLE, READ, MODIFY, WRITE, RESP.
  - IDLE: evaluate the arbiter. On accept, latch index, address, data, op, aq and rl.
    - Valid request: go to READ.
    - Bad address or bad op: go to RESP with `resp_err=1` and no memory access.
  - READ: `mem_en=1`, `mem_we=0`.
  - MODIFY: capture `mem_rdata` as old; compute new.
  - WRITE: `mem_en=1`, `mem_we=1`, `mem_wdata`=new.
  - RESP: `resp_valid[idx]=1`, then return to IDLE.
- Arbiter:
  - Round-robin. Search starts at last_grant+1 and wraps at `NUM_REQ`.
  - `last_grant` updates only on accept.
  - `req_ready` is nonzero only in IDLE and has at most one bit set.
- Lock:
  - A completed, non-error request with aq=1 sets `lock_owner` to that requester.
  - While locked, only the owner can be granted; other requesters stall with `req_ready=0`.
  - A completed owner request with rl=1 clears the lock.
  - aq=1 and rl=1 on the same request: lock state is unchanged.
  - An error response does not change lock state.
- Requester inputs are sampled only at accept. Changes after accept have no effect on the in-flight operation.

## Timing
- Reset values:
  - State = IDLE, `last_grant = NUM_REQ-1` (requester 0 wins first), lock cleared.
  - All outputs 0, including `req_ready`, `resp_valid`, `resp_data`, `resp_err` and the `mem_*` outputs.
- Latency from the accept cycle T:
  - Valid request: READ at T+1, MODIFY at T+2, WRITE at T+3, `resp_valid` at T+4.
  - Error request: `resp_valid` at T+1.
- Throughput: one AMO per 5 cycles. Back-to-back accepts are at best T, T+5.
- Same-address ops from different requesters are serialized by construction. The second op reads the first op's written value.
- Reset mid-operation aborts immediately. No write is issued after `rst_n` falls; no response is produced for the aborted op.
- `resp_data` and `resp_err` hold their values until the next RESP.

## Configuration
- `AMO_MINMAX_EN` defined:
  - 101 = MIN (signed): new = the smaller of old and rs2 as signed.
  - 110 = MAX (signed): new = the larger of old and rs2 as signed.
- `AMO_MINMAX_EN` undefined: 101 and 110 are error ops. No comparator is synthesized.

## Structure
- Package `amo_pkg` holds:
  - op code localparams;
  - the state enum;
  - the AMO compute function (old, rs2, op -> new).
- Sub-module `amo_rr_arbiter` (parameter `NUM_REQ`):
  - inputs: `req`, `last_grant`, lock enable and `lock_owner`;
  - outputs: one-hot grant and encoded index.
- The top-level module contains the FSM, operand latches, lock register and memory drive.

## Test plan
- Memory model preloaded with mem[16]=5.
- Single ADD: requester 0, addr 16, rs2 3 -> `resp_valid[0]` at T+4 with data 5; mem[16]=8; exactly one read and one write.
- Round-robin: all four requesters valid at once -> grants in order 0,1,2,3,0, each accept 5 cycles apart.
- Errors:
  - addr 300 (`ADDR_W=9`) -> `resp_err=1` at T+1, data 0, no `mem_en`;
  - op 111 -> same.
  - op 101 without `AMO_MINMAX_EN` -> error; with it, old=-2, rs2=1 -> new=-2.
- Lock:
  - requester 1 SWAP with aq=1, then requester 2 valid -> requester 2 stalls;
  - requester 1 OR with rl=1 completes -> requester 2 is granted next cycle.
- Reset: drop `rst_n` during MODIFY -> outputs 0 asynchronously, no write to memory, memory value unchanged, next request serviced normally.
